// File: rtl/sprite_pkg.sv
// Shared types and geometry for the sprite RAM loader.
// One sprite is a 16x16 raster stored at {sid, y[3:0], x[3:0]}.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        LOAD       = 2'd2,
        DONE       = 2'd3
    } loader_state_t;

    localparam int H_SIZE        = 16;
    localparam int V_SIZE        = 16;
    localparam int SPRITE_PIXELS = H_SIZE * V_SIZE;

endpackage

// File: rtl/sprite_ram_loader.sv
// Streams one 16x16 sprite frame into sprite RAM, writing only while
// the display is in vertical blanking so a frame is never torn.
module sprite_ram_loader
    import sprite_pkg::*;
#(
    parameter int CD       = 12,
    parameter int ADDR     = 10,
    parameter int V_ACTIVE = 480
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_sid,
    input  logic            abort,
    input  logic            px_valid,
    output logic            px_ready,
    input  logic [CD-1:0]   px_data,
    input  logic [10:0]     y,
    output logic            we,
    output logic [ADDR-1:0] addr_w,
    output logic [CD-1:0]   pixel_out,
    output logic            busy,
    output logic            done
);

    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [7:0]  LAST_IDX = 8'(SPRITE_PIXELS - 1);

    loader_state_t state;
    loader_state_t state_nx;

    logic [1:0] sid_reg;
    logic [7:0] cnt;
    logic       blank;
    logic       cmd_hs;
    logic       px_hs;
    logic       last_px;

    assign blank   = (y >= V_ACT);
    assign last_px = (cnt == LAST_IDX);

    assign cmd_ready = (state == IDLE);
    assign px_ready  = (state == LOAD) && blank && !abort;
    assign busy      = (state != IDLE);

    assign cmd_hs = cmd_valid && cmd_ready;
    assign px_hs  = px_valid && px_ready;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cmd_hs)
                    state_nx = WAIT_BLANK;
            end
            WAIT_BLANK: begin
                if (abort)
                    state_nx = IDLE;
                else if (blank)
                    state_nx = LOAD;
            end
            LOAD: begin
                if (abort)
                    state_nx = IDLE;
                else if (px_hs && last_px)
                    state_nx = DONE;
                else if (!blank)
                    state_nx = WAIT_BLANK;
            end
            DONE: begin
                // Stay until the registered done pulse has been shown.
                if (abort || done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sid_reg <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (cmd_hs) begin
                sid_reg <= cmd_sid;
                cnt     <= '0;
            end else if (abort && state != IDLE) begin
                cnt <= '0;
            end else if (px_hs) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we        <= 1'b0;
            addr_w    <= '0;
            pixel_out <= '0;
            done      <= 1'b0;
        end else begin
            we   <= px_hs;
            done <= (state == DONE) && !done && !abort;
            if (px_hs) begin
                addr_w    <= ADDR'({sid_reg, cnt});
                pixel_out <= px_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader with a write scoreboard.
// Expected writes are queued at each pixel handshake and popped on we.
module tb_sprite_ram_loader;
    import sprite_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_sid = 2'd0;
    logic        abort = 1'b0;
    logic        px_valid = 1'b0;
    logic        px_ready;
    logic [11:0] px_data = 12'd0;
    logic [10:0] y = 11'd0;
    logic        we;
    logic [9:0]  addr_w;
    logic [11:0] pixel_out;
    logic        busy;
    logic        done;

    sprite_ram_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sid   (cmd_sid),
        .abort     (abort),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_data   (px_data),
        .y         (y),
        .we        (we),
        .addr_w    (addr_w),
        .pixel_out (pixel_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  a;
        logic [11:0] d;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;

    int  cyc = 0;
    int  n_pass = 0;
    int  n_chk = 0;
    int  we_count = 0;
    int  done_count = 0;
    int  last_we_cyc = -10;
    int  done_cyc = -10;
    int  first_we_cyc = -1;
    bit  busy_next = 1'b0;
    bit  watch_cr = 1'b0;
    int  cr_early = 0;
    int  cur_sid = 0;
    int  px_idx = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (busy_next) begin
            busy_next = 1'b0;
            chk("busy_after_done", 32'(busy), 32'd0);
        end
        if (watch_cr && cmd_ready === 1'b1)
            cr_early++;
        if (we === 1'b1) begin
            we_count++;
            last_we_cyc = cyc;
            if (first_we_cyc < 0)
                first_we_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("addr_w", 32'(addr_w), 32'(mon_e.a));
                chk("pixel_out", 32'(pixel_out), 32'(mon_e.d));
            end
        end
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
            chk("done_after_we", cyc - last_we_cyc, 32'd1);
            chk("busy_at_done", 32'(busy), 32'd1);
            busy_next = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] sid, output int hs_cyc);
        bit hs = 1'b0;
        hs_cyc = -1;
        cmd_valid = 1'b1;
        cmd_sid = sid;
        for (int i = 0; i < 2000 && !hs; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                hs = 1'b1;
                hs_cyc = cyc;
            end
            tick();
        end
        if (!hs)
            chk("cmd_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
        cur_sid = int'(sid);
        px_idx = 0;
    endtask

    task automatic push_px(input int n, input bit gap);
        int got = 0;
        int i = 0;
        logic [7:0] ix;
        while (got < n && i < 4000) begin
            px_valid = !gap || (i % 2 == 0);
            px_data = 12'(px_idx);
            @(negedge clk);
            if (px_valid && px_ready) begin
                ix = 8'(px_idx);
                sb.push_back('{a: {2'(cur_sid), ix},
                               d: 12'(px_idx)});
                px_idx++;
                got++;
            end
            tick();
            i++;
        end
        if (got < n)
            chk("px_timeout", 32'(got), 32'(n));
    endtask

    task automatic wait_done();
        int start = done_count;
        for (int i = 0; i < 50 && done_count == start; i++)
            tick();
        chk("done_once", done_count - start, 32'd1);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hc;
        int we0;
        int d0;
        bit rose;
        int rise_cyc;

        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr_w), 32'd0);
        chk("rst_pixel", 32'(pixel_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_px_ready", 32'(px_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Full load inside blank, sid 2.
        y = 11'd500;
        we0 = we_count;
        first_we_cyc = -1;
        send_cmd(2'd2, hc);
        push_px(256, 1'b0);
        wait_done();
        chk("full_latency", first_we_cyc - hc, 32'd3);
        chk("full_thruput", last_we_cyc - first_we_cyc, 32'd255);
        chk("full_we_cnt", we_count - we0, 32'd256);
        chk("full_sb_empty", sb.size(), 32'd0);

        // Blank ends after 100 pixels.
        we0 = we_count;
        send_cmd(2'd3, hc);
        push_px(100, 1'b0);
        y = 11'd0;
        px_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("active_px_ready", 32'(px_ready), 32'd0);
            chk("active_busy", 32'(busy), 32'd1);
            tick();
        end
        y = 11'd500;
        push_px(156, 1'b0);
        wait_done();
        chk("resume_we_cnt", we_count - we0, 32'd256);
        chk("resume_sb_empty", sb.size(), 32'd0);

        // Backpressure: px_valid every other cycle.
        we0 = we_count;
        send_cmd(2'd0, hc);
        push_px(256, 1'b1);
        wait_done();
        chk("bp_we_cnt", we_count - we0, 32'd256);
        chk("bp_sb_empty", sb.size(), 32'd0);

        // Abort at pixel 50, then reload sid 1.
        d0 = done_count;
        send_cmd(2'd2, hc);
        push_px(50, 1'b0);
        px_valid = 1'b1;
        px_data = 12'd50;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_px_ready", 32'(px_ready), 32'd0);
        tick();
        abort = 1'b0;
        px_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (5) tick();
        chk("abort_no_done", done_count - d0, 32'd0);
        chk("abort_sb_empty", sb.size(), 32'd0);
        send_cmd(2'd1, hc);
        push_px(256, 1'b0);
        wait_done();
        chk("reload_sb_empty", sb.size(), 32'd0);

        // Asynchronous reset in the middle of a load.
        d0 = done_count;
        send_cmd(2'd0, hc);
        push_px(30, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        sb.delete();
        px_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_px_ready", 32'(px_ready), 32'd0);
        repeat (3) tick();
        chk("arst_no_done", done_count - d0, 32'd0);

        // Command held high during a load.
        send_cmd(2'd1, hc);
        cmd_valid = 1'b1;
        cmd_sid = 2'd3;
        cr_early = 0;
        watch_cr = 1'b1;
        d0 = done_count;
        push_px(256, 1'b0);
        rose = 1'b0;
        rise_cyc = -1;
        for (int i = 0; i < 20 && !rose; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                rose = 1'b1;
                rise_cyc = cyc;
            end else begin
                tick();
            end
        end
        watch_cr = 1'b0;
        chk("busy_cmd_ready_low", 32'(cr_early), 32'd0);
        chk("busy_done_seen", done_count - d0, 32'd1);
        chk("cmd_ready_rise", rise_cyc - done_cyc, 32'd1);
        tick();
        cmd_valid = 1'b0;
        cur_sid = 3;
        px_idx = 0;
        push_px(4, 1'b0);
        px_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        chk("second_cmd_sb", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sprite_ram_loader.md
# sprite_ram_loader

- Writes one complete 16x16 sprite frame into the sprite RAM of a sprite source block.
- Accepts a sprite-id command, then a stream of 256 raster-order pixel words over a valid/ready handshake.
- Drives the RAM write port (`we`, `addr_w`, pixel data) only during vertical blanking, so a frame is never torn mid-scan.
- Sits between the host bus interface and the sprite source's write port.

## Interface

Parameters:
- `CD`, 12, color depth; width of pixel words.
- `ADDR`, 10, sprite RAM address width; equals 2 sid bits + 8 pixel-index bits.
- `V_ACTIVE`, 480, first blanking line; `y >= V_ACTIVE` means vertical blanking.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: load command offered.
- `cmd_ready` out 1: command accepted when both are high.
- `cmd_sid` in 2: target sprite id, sampled on command handshake.
- `abort` in 1: synchronous cancel of the load in progress.
- `px_valid` in 1: pixel word offered.
- `px_ready` out 1: pixel accepted when both are high.
- `px_data` in CD: pixel RGB, raster order, row-major, x fastest.
- `y` in 11: current scan line from the video sync counter.
- `we` out 1: sprite RAM write enable.
- `addr_w` out ADDR: sprite RAM write address.
- `pixel_out` out CD: sprite RAM write data.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse after the 256th write.

## Operation

- FSM states: IDLE, WAIT_BLANK, LOAD, DONE. Reset state is IDLE.
- IDLE:
  - `cmd_ready` = 1.
  - On command handshake: latch `cmd_sid` into `sid_reg`, clear the 8-bit `cnt`, go to WAIT_BLANK.
- WAIT_BLANK: when `y >= V_ACTIVE`, go to LOAD.
- LOAD:
  - `px_ready` = (`y >= V_ACTIVE`) && !`abort`. This is combinational from the state and inputs.
  - Each pixel handshake registers `we` = 1, `addr_w` = {`sid_reg`, `cnt`}, `pixel_out` = `px_data`, then increments `cnt`.
  - If `y < V_ACTIVE` (blank ended), go to WAIT_BLANK. `cnt` is kept and the load resumes on the next blank.
  - The handshake with `cnt` == 255 goes to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `abort` in WAIT_BLANK, LOAD or DONE:
  - Next state is IDLE and `cnt` is cleared.
  - No handshake completes in the abort cycle, and no further `we`.
  - A write registered in the previous cycle still appears.
  - `done` is not pulsed. If `abort` coincides with DONE, `done` is suppressed.
- `cmd_ready` = 0 and `px_ready` = 0 outside IDLE and LOAD respectively.
- Arithmetic:
  - `cnt` is unsigned 8-bit. `cnt[3:0]` is x and `cnt[7:4]` is y, matching the sprite source read address {sid, yr[3:0], xr[3:0]}.
  - Wrap 255→0 never occurs within a load, because DONE is entered first.
- Partially loaded frames are not rolled back on abort; the host reloads.

## Timing

- Reset values while `reset_n` = 0: `we` = 0, `addr_w` = 0, `pixel_out` = 0, `done` = 0, `busy` = 0. `cmd_ready` = 1 and `px_ready` = 0.
- Reset asserted mid-load: immediate return to IDLE, counters cleared, `we` forced 0 asynchronously.
- Write latency: 1 cycle from pixel handshake edge to `we`/`addr_w`/`pixel_out`. `we` is high for exactly one cycle per accepted pixel.
- Throughput: one pixel per cycle while in LOAD, in blank, and `px_valid` stays high.
- `done` asserts in the cycle after the write of pixel 255 is registered. `busy` falls the cycle after `done`.
- Minimum command-to-first-write time:
  - 2 cycles: command → WAIT_BLANK → LOAD handshake, then +1 cycle to `we`.
  - This holds when blank is already active.
- `y` is treated as synchronous to `clk`; no synchronizer.

## Structure

- Shared package `sprite_pkg`:
  - state enum `loader_state_t`
  - constants `H_SIZE` = 16, `V_SIZE` = 16, `SPRITE_PIXELS` = 256
- Single module, no sub-module. The FSM, counter and output registers are tightly coupled.

## Test plan

- **Full load in blank:**
  - Stimulus: `y` = 500, command with sid = 2, then 256 back-to-back pixels with `px_data` = index.
  - Required: 256 `we` pulses; `addr_w` runs 0x200..0x2FF with `pixel_out` equal to the low 12 bits of the index; `done` pulses once 1 cycle after the last `we`.
- **Blank ends mid-load:**
  - Stimulus: `y` drops to 0 after 100 pixels.
  - Required: `px_ready` = 0 and no `we` during the active lines; resume on the next blank at `addr_w` = {sid, 100}; all 256 written exactly once.
- **Backpressure:**
  - Stimulus: `px_valid` toggled every other cycle.
  - Required: writes only on handshake cycles; addresses contiguous with no gaps or repeats.
- **Abort:**
  - Stimulus: `abort` asserted at pixel 50 while `px_valid` = 1.
  - Required: pixel 50 is not written; state IDLE next cycle; `done` never pulses; a new command with sid = 1 starts at `addr_w` = 0x100.
- **Async reset mid-load:**
  - Stimulus: `reset_n` low for 3 cycles during LOAD.
  - Required: `we`, `busy` and `done` are 0 immediately; `cmd_ready` = 1 after release.
- **Command while busy:**
  - Stimulus: `cmd_valid` held high during a load.
  - Required: `cmd_ready` stays 0 until the cycle after `done`; the second command is accepted then.
